// File: rtl/bus_pkg.sv
// ============================================================================
//  bus_pkg : host indices and defaults shared by the bus arbiter slice
//  Revision: 1.0
// ============================================================================
`default_nettype none

package bus_pkg;

    localparam int unsigned c_DefaultNrHosts = 3;

    typedef enum logic [1:0] {
        TestUtilHost = 2'd0,
        CoreD        = 2'd1,
        CoreI        = 2'd2
    } bus_host_e;

endpackage

`default_nettype wire

// File: rtl/bus_id_fifo.sv
// ============================================================================
//  bus_id_fifo : in-order FIFO of host IDs for outstanding bus transactions
//  Revision: 1.0
// ============================================================================
`default_nettype none

module bus_id_fifo #(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push_i,
    input  logic [Width-1:0]             data_i,
    input  logic                         pop_i,
    output logic [Width-1:0]             data_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(Depth+1)-1:0]   count_o
);

    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [CntW-1:0] count_q, count_d;
    logic            w_push, w_pop;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    // A pop in the same cycle makes room, so push is accepted even when full.
    assign w_push  = push_i & (~full_o | pop_i);
    assign w_pop   = pop_i & ~empty_o;

    always_comb begin
        count_d = count_q;
        if (w_push && !w_pop) begin
            count_d = count_q + CntW'(1);
        end else if (!w_push && w_pop) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    generate
        if (Depth == 1) begin : g_single
            logic [Width-1:0] id_q;

            always_ff @(posedge clk_i) begin
                if (w_push) begin
                    id_q <= data_i;
                end
            end

            assign data_o = id_q;
        end else begin : g_ring
            localparam int unsigned PtrW = $clog2(Depth);

            logic [Width-1:0] mem_q [Depth];
            logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                end else begin
                    if (w_push) begin
                        wr_ptr_q <= wr_ptr_q + PtrW'(1);
                    end
                    if (w_pop) begin
                        rd_ptr_q <= rd_ptr_q + PtrW'(1);
                    end
                end
            end

            always_ff @(posedge clk_i) begin
                if (w_push) begin
                    mem_q[wr_ptr_q] <= data_i;
                end
            end

            assign data_o = mem_q[rd_ptr_q];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/bus_rr_arbiter.sv
// ============================================================================
//  bus_rr_arbiter : round-robin sharing of one device bus port among hosts,
//                   with in-order response routing
//  Revision: 1.0
// ============================================================================
`default_nettype none

module bus_rr_arbiter
    import bus_pkg::*;
#(
    parameter int unsigned NrHosts        = c_DefaultNrHosts,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned AddressWidth   = 32,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NrHosts-1:0]                host_req_i,
    output logic [NrHosts-1:0]                host_gnt_o,
    input  logic [NrHosts*AddressWidth-1:0]   host_addr_i,
    input  logic [NrHosts-1:0]                host_we_i,
    input  logic [NrHosts*DataWidth/8-1:0]    host_be_i,
    input  logic [NrHosts*DataWidth-1:0]      host_wdata_i,
    output logic [NrHosts-1:0]                host_rvalid_o,
    output logic [DataWidth-1:0]              host_rdata_o,
    output logic [NrHosts-1:0]                host_err_o,
    output logic                              dev_req_o,
    input  logic                              dev_gnt_i,
    output logic [AddressWidth-1:0]           dev_addr_o,
    output logic                              dev_we_o,
    output logic [DataWidth/8-1:0]            dev_be_o,
    output logic [DataWidth-1:0]              dev_wdata_o,
    input  logic                              dev_rvalid_i,
    input  logic [DataWidth-1:0]              dev_rdata_i,
    input  logic                              dev_err_i,
    output logic                              spurious_rsp_o
);

    localparam int unsigned IdW  = $clog2(NrHosts);
    localparam int unsigned BeW  = DataWidth / 8;
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    // Returns {found, index}: first requester at or above last+1, with wrap.
    function automatic logic [IdW:0] rr_pick(input logic [NrHosts-1:0] req,
                                             input logic [IdW-1:0]     last);
        logic [2*NrHosts-1:0] dbl;
        logic [NrHosts-1:0]   rot;
        int unsigned          start;
        logic [IdW:0]         res;
        dbl   = {req, req};
        start = (32'(last) + 32'd1) % NrHosts;
        rot   = dbl[start +: NrHosts];
        res   = '0;
        for (int k = NrHosts - 1; k >= 0; k--) begin
            if (rot[k]) begin
                res = {1'b1, IdW'((start + unsigned'(k)) % NrHosts)};
            end
        end
        return res;
    endfunction

    logic [IdW-1:0]  last_ptr_q, last_ptr_d;
    logic            lock_valid_q, lock_valid_d;
    logic [IdW-1:0]  lock_id_q, lock_id_d;
    logic            spurious_q, spurious_d;

    logic [IdW:0]    w_rr;
    logic            w_lock_hit;
    logic            w_cand_valid;
    logic [IdW-1:0]  w_cand;
    logic            w_hs;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;
    logic [IdW-1:0]  w_head;
    logic [CntW-1:0] w_count;
    logic            w_unused_count;

    // A held-off candidate keeps the port until it is granted or withdraws.
    assign w_rr         = rr_pick(host_req_i, last_ptr_q);
    assign w_lock_hit   = lock_valid_q & host_req_i[lock_id_q];
    assign w_cand       = w_lock_hit ? lock_id_q : w_rr[IdW-1:0];
    assign w_cand_valid = w_lock_hit | w_rr[IdW];

    assign dev_req_o      = w_cand_valid & ~w_full;
    assign w_hs           = dev_req_o & dev_gnt_i;
    assign w_pop          = dev_rvalid_i & ~w_empty;
    assign host_rdata_o   = dev_rdata_i;
    assign spurious_rsp_o = spurious_q;
    assign w_unused_count = ^w_count;

    always_comb begin
        dev_addr_o    = '0;
        dev_we_o      = 1'b0;
        dev_be_o      = '0;
        dev_wdata_o   = '0;
        host_gnt_o    = '0;
        host_rvalid_o = '0;
        host_err_o    = '0;
        for (int h = 0; h < NrHosts; h++) begin
            if (w_cand == IdW'(h)) begin
                dev_addr_o    = host_addr_i[h*AddressWidth +: AddressWidth];
                dev_we_o      = host_we_i[h];
                dev_be_o      = host_be_i[h*BeW +: BeW];
                dev_wdata_o   = host_wdata_i[h*DataWidth +: DataWidth];
                host_gnt_o[h] = w_hs;
            end
            if (w_head == IdW'(h)) begin
                host_rvalid_o[h] = w_pop;
                host_err_o[h]    = w_pop & dev_err_i;
            end
        end
    end

    always_comb begin
        last_ptr_d   = last_ptr_q;
        lock_valid_d = 1'b0;
        lock_id_d    = lock_id_q;
        spurious_d   = spurious_q | (dev_rvalid_i & w_empty);
        if (w_hs) begin
            last_ptr_d = w_cand;
        end else if (dev_req_o) begin
            lock_valid_d = 1'b1;
            lock_id_d    = w_cand;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_ptr_q   <= IdW'(NrHosts - 1);
            lock_valid_q <= 1'b0;
            lock_id_q    <= '0;
            spurious_q   <= 1'b0;
        end else begin
            last_ptr_q   <= last_ptr_d;
            lock_valid_q <= lock_valid_d;
            lock_id_q    <= lock_id_d;
            spurious_q   <= spurious_d;
        end
    end

    bus_id_fifo #(
        .Depth (MaxOutstanding),
        .Width (IdW)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_hs),
        .data_i  (w_cand),
        .pop_i   (w_pop),
        .data_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (w_count)
    );

    a_gnt_onehot0: assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0(host_gnt_o));

    a_rvalid_onehot0: assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0(host_rvalid_o));

    a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i)
        !(w_hs && w_full));

    a_req_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (dev_req_o && !dev_gnt_i) |=> (dev_req_o && $stable(dev_addr_o) &&
            $stable(dev_we_o) && $stable(dev_be_o) && $stable(dev_wdata_o)));

endmodule

`default_nettype wire

// File: tb/tb_bus_rr_arbiter.sv
// ============================================================================
//  tb_bus_rr_arbiter : directed scoreboard bench for bus_rr_arbiter
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_bus_rr_arbiter;

    localparam int NH = 3;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int MO = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [NH-1:0]      host_req;
    logic [NH-1:0]      host_gnt;
    logic [NH*AW-1:0]   host_addr;
    logic [NH-1:0]      host_we;
    logic [NH*DW/8-1:0] host_be;
    logic [NH*DW-1:0]   host_wdata;
    logic [NH-1:0]      host_rvalid;
    logic [DW-1:0]      host_rdata;
    logic [NH-1:0]      host_err;
    logic               dev_req;
    logic               dev_gnt;
    logic [AW-1:0]      dev_addr;
    logic               dev_we;
    logic [DW/8-1:0]    dev_be;
    logic [DW-1:0]      dev_wdata;
    logic               dev_rvalid;
    logic [DW-1:0]      dev_rdata;
    logic               dev_err;
    logic               spurious;

    bus_rr_arbiter #(
        .NrHosts        (NH),
        .DataWidth      (DW),
        .AddressWidth   (AW),
        .MaxOutstanding (MO)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .host_req_i     (host_req),
        .host_gnt_o     (host_gnt),
        .host_addr_i    (host_addr),
        .host_we_i      (host_we),
        .host_be_i      (host_be),
        .host_wdata_i   (host_wdata),
        .host_rvalid_o  (host_rvalid),
        .host_rdata_o   (host_rdata),
        .host_err_o     (host_err),
        .dev_req_o      (dev_req),
        .dev_gnt_i      (dev_gnt),
        .dev_addr_o     (dev_addr),
        .dev_we_o       (dev_we),
        .dev_be_o       (dev_be),
        .dev_wdata_o    (dev_wdata),
        .dev_rvalid_i   (dev_rvalid),
        .dev_rdata_i    (dev_rdata),
        .dev_err_i      (dev_err),
        .spurious_rsp_o (spurious)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          host;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t exp_gnt_q[$];
    exp_t exp_rsp_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic expect_gnt(input int h, input logic [31:0] addr);
        exp_t e;
        e.host = h; e.data = addr; e.err = 1'b0;
        exp_gnt_q.push_back(e);
    endtask

    task automatic expect_rsp(input int h, input logic [31:0] data, input logic err);
        exp_t e;
        e.host = h; e.data = data; e.err = err;
        exp_rsp_q.push_back(e);
    endtask

    task automatic set_host(input int h, input logic [31:0] addr, input logic we,
                            input logic [3:0] be, input logic [31:0] wdata);
        host_addr[h*AW +: AW]  = addr;
        host_we[h]             = we;
        host_be[h*4 +: 4]      = be;
        host_wdata[h*DW +: DW] = wdata;
    endtask

    // Monitor: every cycle either an output or an expectation triggers a compare.
    always @(negedge clk) begin : mon
        exp_t e;
        logic [NH-1:0] vec;
        if (!rst) begin
            if (host_gnt != '0 || exp_gnt_q.size() != 0) begin
                if (exp_gnt_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL gnt_unexpected actual=%b required=000", host_gnt);
                end else begin
                    e   = exp_gnt_q.pop_front();
                    vec = 3'b001 << e.host;
                    chk("gnt_vec", 32'(host_gnt), 32'(vec));
                    chk("gnt_addr", dev_addr, e.data);
                end
            end
            if (host_rvalid != '0 || exp_rsp_q.size() != 0) begin
                if (exp_rsp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rvalid_unexpected actual=%b required=000", host_rvalid);
                end else begin
                    e   = exp_rsp_q.pop_front();
                    vec = 3'b001 << e.host;
                    chk("rsp_vec", 32'(host_rvalid), 32'(vec));
                    chk("rsp_data", host_rdata, e.data);
                    chk("rsp_err", 32'(host_err), e.err ? 32'(vec) : 32'd0);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        host_req   = '0;
        host_addr  = '0;
        host_we    = '0;
        host_be    = '0;
        host_wdata = '0;
        dev_gnt    = 1'b0;
        dev_rvalid = 1'b0;
        dev_rdata  = '0;
        dev_err    = 1'b0;

        // Reset state
        step();
        settle();
        chk("rst_gnt", 32'(host_gnt), 32'd0);
        chk("rst_rvalid", 32'(host_rvalid), 32'd0);
        chk("rst_err", 32'(host_err), 32'd0);
        chk("rst_dev_req", 32'(dev_req), 32'd0);
        chk("rst_spurious", 32'(spurious), 32'd0);
        step();
        rst = 1'b0;

        // Single host read
        step();
        set_host(1, 32'h100, 1'b0, 4'hF, 32'h0);
        host_req = 3'b010;
        dev_gnt  = 1'b1;
        expect_gnt(1, 32'h100);
        settle();
        chk("single_dev_req", 32'(dev_req), 32'd1);
        step();
        host_req   = '0;
        dev_gnt    = 1'b0;
        dev_rvalid = 1'b1;
        dev_rdata  = 32'hDEADBEEF;
        expect_rsp(1, 32'hDEADBEEF, 1'b0);
        step();
        dev_rvalid = 1'b0;
        dev_rdata  = '0;

        // Fairness from a fresh reset: grants 0,1,2,0,1,2
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int h = 0; h < NH; h++) begin
            set_host(h, 32'h1000_0000 + 32'(h) * 32'h10, 1'b0, 4'hF, 32'h0);
        end
        for (int k = 0; k < 7; k++) begin
            step();
            host_req   = (k < 6) ? 3'b111 : 3'b000;
            dev_gnt    = (k < 6);
            dev_rvalid = (k >= 1);
            dev_rdata  = (k >= 1) ? 32'h1000 + 32'(k - 1) : 32'h0;
            if (k < 6) expect_gnt(k % 3, 32'h1000_0000 + 32'(k % 3) * 32'h10);
            if (k >= 1) expect_rsp((k - 1) % 3, 32'h1000 + 32'(k - 1), 1'b0);
        end
        step();
        dev_rvalid = 1'b0;
        dev_rdata  = '0;

        // Backpressure: FIFO of two fills, one pop allows exactly one more grant
        step();
        host_req = 3'b111;
        dev_gnt  = 1'b1;
        expect_gnt(0, 32'h1000_0000);
        step();
        expect_gnt(1, 32'h1000_0010);
        step();
        settle();
        chk("bp_full_req", 32'(dev_req), 32'd0);
        step();
        dev_rvalid = 1'b1;
        dev_rdata  = 32'h2000;
        expect_rsp(0, 32'h2000, 1'b0);
        settle();
        chk("bp_pop_cycle_req", 32'(dev_req), 32'd0);
        step();
        dev_rvalid = 1'b0;
        dev_rdata  = '0;
        expect_gnt(2, 32'h1000_0020);
        step();
        settle();
        chk("bp_refull_req", 32'(dev_req), 32'd0);
        step();
        host_req   = '0;
        dev_gnt    = 1'b0;
        dev_rvalid = 1'b1;
        dev_rdata  = 32'h2001;
        expect_rsp(1, 32'h2001, 1'b0);
        step();
        dev_rdata = 32'h2002;
        expect_rsp(2, 32'h2002, 1'b0);
        step();
        dev_rvalid = 1'b0;
        dev_rdata  = '0;

        // Grant stall: host 2 keeps the port although host 0 arrives later
        set_host(0, 32'h0A0, 1'b0, 4'hF, 32'h0);
        set_host(2, 32'h300, 1'b0, 4'h3, 32'h0);
        step();
        host_req = 3'b100;
        dev_gnt  = 1'b0;
        settle();
        chk("stall_req", 32'(dev_req), 32'd1);
        chk("stall_addr0", dev_addr, 32'h300);
        step();
        settle();
        chk("stall_addr1", dev_addr, 32'h300);
        step();
        host_req = 3'b101;
        settle();
        chk("stall_addr2", dev_addr, 32'h300);
        chk("stall_no_gnt", 32'(host_gnt), 32'd0);
        step();
        dev_gnt = 1'b1;
        expect_gnt(2, 32'h300);
        step();
        host_req   = 3'b001;
        dev_rvalid = 1'b1;
        dev_rdata  = 32'h3000;
        expect_rsp(2, 32'h3000, 1'b0);
        expect_gnt(0, 32'h0A0);
        step();
        host_req  = '0;
        dev_gnt   = 1'b0;
        dev_rdata = 32'h3001;
        expect_rsp(0, 32'h3001, 1'b0);
        step();
        dev_rvalid = 1'b0;
        dev_rdata  = '0;

        // Error response, then a spurious one
        set_host(0, 32'h400, 1'b1, 4'hC, 32'hCAFEF00D);
        step();
        host_req = 3'b001;
        dev_gnt  = 1'b1;
        expect_gnt(0, 32'h400);
        settle();
        chk("wr_we", 32'(dev_we), 32'd1);
        chk("wr_be", 32'(dev_be), 32'hC);
        chk("wr_wdata", dev_wdata, 32'hCAFEF00D);
        step();
        host_req   = '0;
        dev_gnt    = 1'b0;
        dev_rvalid = 1'b1;
        dev_err    = 1'b1;
        expect_rsp(0, 32'h0, 1'b1);
        step();
        dev_err   = 1'b0;
        dev_rdata = 32'h55;
        settle();
        chk("spur_rdata_pass", host_rdata, 32'h55);
        chk("spur_before", 32'(spurious), 32'd0);
        step();
        dev_rvalid = 1'b0;
        dev_rdata  = '0;
        settle();
        chk("spur_set", 32'(spurious), 32'd1);
        step();
        settle();
        chk("spur_held", 32'(spurious), 32'd1);

        // Reset with two transactions in flight
        set_host(1, 32'h510, 1'b0, 4'hF, 32'h0);
        set_host(2, 32'h520, 1'b0, 4'hF, 32'h0);
        step();
        host_req = 3'b110;
        dev_gnt  = 1'b1;
        expect_gnt(1, 32'h510);
        step();
        expect_gnt(2, 32'h520);
        step();
        host_req = '0;
        dev_gnt  = 1'b0;
        rst      = 1'b1;
        settle();
        chk("mid_spur_pre", 32'(spurious), 32'd1);
        step();
        rst = 1'b0;
        settle();
        chk("mid_spur_clr", 32'(spurious), 32'd0);
        chk("mid_dev_req", 32'(dev_req), 32'd0);
        chk("mid_gnt", 32'(host_gnt), 32'd0);
        chk("mid_rvalid", 32'(host_rvalid), 32'd0);
        step();
        set_host(0, 32'h500, 1'b0, 4'hF, 32'h0);
        host_req = 3'b111;
        dev_gnt  = 1'b1;
        expect_gnt(0, 32'h500);
        step();
        host_req   = '0;
        dev_gnt    = 1'b0;
        dev_rvalid = 1'b1;
        dev_rdata  = 32'h6000;
        expect_rsp(0, 32'h6000, 1'b0);
        step();
        dev_rdata = 32'h6001;
        settle();
        chk("mid_stale_rvalid", 32'(host_rvalid), 32'd0);
        step();
        dev_rvalid = 1'b0;
        dev_rdata  = '0;
        settle();
        chk("mid_stale_spur", 32'(spurious), 32'd1);

        step();
        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
